// File: rtl/ob_pkg.sv
// ob_pkg: shared types and helpers for the ob_* blocks.
package ob_pkg;
    typedef enum logic [1:0] {CSA_3_2, CSA_4_2} csa_op_t;
    typedef enum logic [2:0] {IDLE, FETCH, DRAIN, SUM, RESP} ob_table_cnt_state_t;
    function automatic int addr_w(input int b);
        return (b > 1) ? $clog2(b) : 1;
    endfunction
endpackage

// File: rtl/ob_table_cnt_csa.sv
// ob_table_cnt_csa: reduces NI operands of width W to a carry-save sum/carry pair.
module ob_table_cnt_csa
    import ob_pkg::*;
#(
    parameter int W = 32,
    parameter int NI = 10,
    parameter csa_op_t OP = ob_pkg::CSA_3_2
) (
    input  logic [NI-1:0][W-1:0] ops,
    output logic [W-1:0]         sum,
    output logic [W-1:0]         carry
);
    function automatic logic [2*W-1:0] fa(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] d);
        return {a ^ b ^ d, ((a & b) | (a & d) | (b & d)) << 1};
    endfunction
    logic [W-1:0] s, c, p, q;
    always_comb begin
        s = ops[0];
        c = ops[1];
        p = '0;
        q = '0;
        if (OP == CSA_4_2) begin
            // 4:2 step: two new operands enter the first layer, the running carry the second
            for (int i = 2; i + 1 < NI; i += 2) begin
                {p, q} = fa(ops[i], ops[i+1], s);
                {s, c} = fa(p, q, c);
            end
            if (NI % 2 == 1)
                {s, c} = fa(s, c, ops[NI-1]);
        end else begin
            for (int i = 2; i < NI; i++)
                {s, c} = fa(s, c, ops[i]);
        end
    end
    assign sum   = s;
    assign carry = c;
endmodule

// File: rtl/ob_table_cnt_ctl.sv
// ob_table_cnt_ctl: sums ENTRIES table words fetched N per beat into a W-bit count.
// Optional OB_TABLE_CNT_PERF_EN adds a saturating busy-cycle counter perf_cyc.
module ob_table_cnt_ctl
    import ob_pkg::*;
#(
    parameter int W = 32,
    parameter int N = 8,
    parameter int ENTRIES = 64,
    parameter csa_op_t OP = ob_pkg::CSA_3_2
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                start_vld,
    output logic                                start_rdy,
    input  logic                                abort,
    output logic                                rd_en,
    output logic [addr_w(ENTRIES/N)-1:0]        rd_addr,
    input  logic [N-1:0][W-1:0]                 rd_data,
    output logic                                rsp_vld,
    input  logic                                rsp_rdy,
    output logic [W-1:0]                        rsp_cnt,
`ifdef OB_TABLE_CNT_PERF_EN
    output logic [31:0]                         perf_cyc,
`endif
    output logic                                busy
);
    localparam int B = ENTRIES / N;
    localparam int AW = addr_w(B);
    ob_table_cnt_state_t state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic rd_vld_q, rd_vld_d;
    logic [W-1:0] acc_s_q, acc_s_d, acc_c_q, acc_c_d, rsp_cnt_q, rsp_cnt_d, csa_s, csa_c;
    logic start_acc, last_beat;
    logic [N+1:0][W-1:0] csa_in;
    assign start_rdy = state_q == IDLE;
    assign busy      = !start_rdy;
    assign rd_en     = state_q == FETCH;
    assign rd_addr   = addr_q;
    assign rsp_vld   = state_q == RESP;
    assign rsp_cnt   = rsp_cnt_q;
    assign start_acc = start_rdy && start_vld && !abort;
    assign last_beat = addr_q == AW'(B - 1);
    assign csa_in    = {acc_c_q, acc_s_q, rd_data};
    ob_table_cnt_csa #(.W(W), .NI(N + 2), .OP(OP)) u_csa (
        .ops   (csa_in),
        .sum   (csa_s),
        .carry (csa_c)
    );
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start_vld ? FETCH : IDLE;
            FETCH:   state_d = last_beat ? DRAIN : FETCH;
            DRAIN:   state_d = SUM;
            SUM:     state_d = RESP;
            RESP:    state_d = rsp_rdy ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
        if (abort)
            state_d = IDLE;
        addr_d    = (rd_en && !last_beat && !abort) ? addr_q + AW'(1) : '0;
        // a beat is in flight one cycle behind each read; abort drops it
        rd_vld_d  = rd_en && !abort;
        acc_s_d   = start_acc ? '0 : rd_vld_q ? csa_s : acc_s_q;
        acc_c_d   = start_acc ? '0 : rd_vld_q ? csa_c : acc_c_q;
        rsp_cnt_d = (state_q == SUM) ? acc_s_q + acc_c_q : rsp_cnt_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            rd_vld_q  <= 1'b0;
            acc_s_q   <= '0;
            acc_c_q   <= '0;
            rsp_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rd_vld_q  <= rd_vld_d;
            acc_s_q   <= acc_s_d;
            acc_c_q   <= acc_c_d;
            rsp_cnt_q <= rsp_cnt_d;
        end
    end
`ifdef OB_TABLE_CNT_PERF_EN
    logic [31:0] perf_cyc_q, perf_cyc_d;
    assign perf_cyc_d = (busy && perf_cyc_q != '1) ? perf_cyc_q + 32'd1 : perf_cyc_q;
    assign perf_cyc   = perf_cyc_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            perf_cyc_q <= '0;
        else
            perf_cyc_q <= perf_cyc_d;
    end
`endif
endmodule

// File: doc/ob_table_cnt_ctl.md
OB_TABLE_CNT_CTL -- requirements
Module: ob_table_cnt_ctl

Interface
REQ-001 SHALL have parameter W, default 32, meaning count and table word width in bits.
REQ-002 SHALL have parameter N, default 8, meaning words read per beat and CSA input count.
REQ-003 SHALL have parameter ENTRIES, default 64, meaning table words to sum; it SHALL be a multiple of N, and B = ENTRIES/N.
REQ-004 SHALL have parameter OP, default ob_pkg::CSA_3_2, meaning the CSA compression function passed to the reduction sub-module.
REQ-005 SHALL have port clk, input, 1, the single clock.
REQ-006 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-007 SHALL have port start_vld, input, 1, request to begin a count.
REQ-008 SHALL have port start_rdy, output, 1, high only in IDLE.
REQ-009 SHALL have port abort, input, 1, cancel in-flight count.
REQ-010 SHALL have port rd_en, output, 1, table read strobe.
REQ-011 SHALL have port rd_addr, output, $clog2(B) (min 1), beat index.
REQ-012 SHALL have port rd_data, input, N x W, table words, valid exactly 1 cycle after rd_en.
REQ-013 SHALL have port rsp_vld, output, 1, count valid.
REQ-014 SHALL have port rsp_rdy, input, 1, count consumed.
REQ-015 SHALL have port rsp_cnt, output, W, sum of all ENTRIES words.
REQ-016 SHALL have port busy, output, 1, high in any state except IDLE.

Function
REQ-017 SHALL implement states IDLE, FETCH, DRAIN, SUM and RESP.
- IDLE->FETCH on start_vld & start_rdy; accumulators acc_s/acc_c cleared to 0 on that edge.
- FETCH issues rd_en=1 with rd_addr=0..B-1 on consecutive cycles, one beat per cycle, no gaps; after beat B-1 -> DRAIN.
- DRAIN lasts 1 cycle, absorbing the final return beat -> SUM.
REQ-018 Each returned beat SHALL be reduced with acc_s and acc_c (N+2 operands) into new carry-save acc_s/acc_c in the same cycle the data returns.
REQ-019 SUM SHALL register rsp_cnt = acc_s + acc_c (modulo 2^W, overflow discarded) -> RESP.
REQ-020 RESP SHALL hold rsp_vld=1 and rsp_cnt stable until rsp_rdy=1, then -> IDLE.
REQ-021 With start accepted at cycle 0, rsp_vld SHALL first assert at cycle B+3.
REQ-022 start_vld while busy SHALL be ignored (no queuing).
REQ-023 abort SHALL force IDLE on the next edge from any state including RESP; no response issued; rd_en deasserts that next cycle; read data returning afterward ignored.
REQ-024 abort and start_vld simultaneously in IDLE: abort wins, start not accepted.
REQ-025 rsp_rdy & rsp_vld in the same cycle as start_vld: start SHALL be accepted the following cycle (start_rdy low during RESP).

Reset
REQ-026 On rst_n low (any time, asynchronous): state=IDLE; rd_en=0, rd_addr=0, rsp_vld=0, rsp_cnt=0, busy=0, start_rdy=1 after release; acc_s=acc_c=0.
REQ-027 Reset mid-operation SHALL discard all progress; no response produced.

Configuration
REQ-028 Macro OB_TABLE_CNT_PERF_EN defined: SHALL add output perf_cyc (32 bits, reset 0) counting cycles with busy=1, saturating at all-ones, cleared by abort-free start acceptance? No -- never cleared except by reset.
REQ-029 Macro undefined: perf_cyc port and counter SHALL be absent; all other behaviour identical.

Structure
REQ-030 ob_pkg SHALL hold the state enum type ob_table_cnt_state_t and reuse existing csa_op_t.
REQ-031 Carry-save reduction SHALL be one instance of ob_table_cnt_csa (N+2 inputs, width W, OP); the controller contains only state, address counter, accumulators and final adder.

Verification
REQ-032 ENTRIES=16, N=4, all words 1, start at cycle 0 -> rd_en cycles 1..4, rd_addr 0..3, rsp_vld at cycle 7, rsp_cnt=16.
REQ-033 Words = index 0..15 -> rsp_cnt=120; rsp_rdy held low 5 cycles -> rsp_vld, rsp_cnt stable throughout.
REQ-034 W=8, all words 0xFF, ENTRIES=16 -> rsp_cnt=0xF0 (wrap).
REQ-035 abort at cycle 2 of FETCH -> IDLE next cycle, rd_en=0, no rsp_vld; new start -> correct count.
REQ-036 rst_n low during DRAIN -> all outputs at reset values immediately; start_vld while busy ignored.
REQ-037 OB_TABLE_CNT_PERF_EN defined, two back-to-back counts of B=4 -> perf_cyc=14 (7 busy cycles each, rsp_rdy=1).
